// File: rtl/instr_encoder_loader.sv
// Assembles 32-bit MIPS instruction words from field-level requests and
// writes them sequentially into the instruction memory write port.
module instr_encoder_loader #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
    parameter int          COUNT_W   = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [3:0]         op_sel_i,
    input  logic [4:0]         rs_i,
    input  logic [4:0]         rt_i,
    input  logic [4:0]         rd_i,
    input  logic [4:0]         shamt_i,
    input  logic [5:0]         funct_i,
    input  logic [15:0]        imm_i,
    input  logic [25:0]        target_i,
    output logic               mem_we_o,
    output logic [31:0]        mem_addr_o,
    output logic [31:0]        mem_wdata_o,
    output logic [COUNT_W-1:0] count_o,
    output logic               full_o,
    output logic               err_o
);

    // state  | meaning
    // IDLE   | ready for a request
    // ENCODE | assemble latched fields, check op_sel legality
    // WRITE  | one-cycle write strobe, advance counter
    // FULL   | DEPTH words written, wait for clear/reset
    typedef enum logic [1:0] {IDLE, ENCODE, WRITE, FULL} state_t;

    state_t               state, state_nxt;
    logic [3:0]           op_q;
    logic [4:0]           rs_q, rt_q, rd_q, shamt_q;
    logic [5:0]           funct_q;
    logic [15:0]          imm_q;
    logic [25:0]          target_q;
    logic [31:0]          enc_word;
    logic                 enc_legal;
    logic                 accept;
    logic [COUNT_W-1:0]   count_q;

    always_comb begin
        enc_legal = 1'b1;
        enc_word  = '0;
        case (op_q)
            4'd0: enc_word = {6'h00, rs_q, rt_q, rd_q, shamt_q, funct_q};
            4'd1: enc_word = {6'h08, rs_q, rt_q, imm_q};
            4'd2: enc_word = {6'h0F, 5'd0, rt_q, imm_q};
            4'd3: enc_word = {6'h0D, rs_q, rt_q, imm_q};
            4'd4: enc_word = {6'h0C, rs_q, rt_q, imm_q};
            4'd5: enc_word = {6'h23, rs_q, rt_q, imm_q};
            4'd6: enc_word = {6'h2B, rs_q, rt_q, imm_q};
            4'd7: enc_word = {6'h04, rs_q, rt_q, imm_q};
            4'd8: enc_word = {6'h05, rs_q, rt_q, imm_q};
            4'd9: enc_word = {6'h02, target_q};
            default: enc_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        ready_o   = 1'b0;
        mem_we_o  = 1'b0;
        full_o    = 1'b0;
        err_o     = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    accept    = 1'b1;
                    state_nxt = ENCODE;
                end
            end
            ENCODE: begin
                err_o     = !enc_legal;
                state_nxt = enc_legal ? WRITE : IDLE;
            end
            WRITE: begin
                mem_we_o  = 1'b1;
                state_nxt = (count_q == COUNT_W'(DEPTH - 1)) ? FULL : IDLE;
            end
            FULL: full_o = 1'b1;
            default: state_nxt = IDLE;
        endcase
        // Abort suppresses this cycle's strobes so a discarded write never reaches memory.
        if (reset || clear_i) begin
            state_nxt = IDLE;
            mem_we_o  = 1'b0;
            err_o     = 1'b0;
            accept    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count_q     <= '0;
            mem_wdata_o <= '0;
        end else begin
            state <= state_nxt;
            if (clear_i)
                count_q <= '0;
            else if (state == WRITE)
                count_q <= count_q + COUNT_W'(1);
            if (state == ENCODE && enc_legal && !clear_i)
                mem_wdata_o <= enc_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            shamt_q  <= '0;
            funct_q  <= '0;
            imm_q    <= '0;
            target_q <= '0;
        end else if (accept) begin
            op_q     <= op_sel_i;
            rs_q     <= rs_i;
            rt_q     <= rt_i;
            rd_q     <= rd_i;
            shamt_q  <= shamt_i;
            funct_q  <= funct_i;
            imm_q    <= imm_i;
            target_q <= target_i;
        end
    end

    assign count_o    = count_q;
    assign mem_addr_o = BASE_ADDR + (32'(count_q) << 2);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed scenarios plus randomized requests
// checked against a field-level encoding model.
module tb_instr_encoder_loader;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset, clear_i, valid_i;
    logic [3:0]  op_sel_i;
    logic [4:0]  rs_i, rt_i, rd_i, shamt_i;
    logic [5:0]  funct_i;
    logic [15:0] imm_i;
    logic [25:0] target_i;

    logic        ready_o, mem_we_o, full_o, err_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [6:0]  count_o;
    logic        ready_d1, we_d1, full_d1, err_d1;
    logic [31:0] addr_d1, wdata_d1;
    logic [6:0]  count_d1;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .COUNT_W(7)) dut (
        .clk(clk), .reset(reset), .clear_i(clear_i), .valid_i(valid_i), .ready_o(ready_o),
        .op_sel_i(op_sel_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .shamt_i(shamt_i),
        .funct_i(funct_i), .imm_i(imm_i), .target_i(target_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .count_o(count_o),
        .full_o(full_o), .err_o(err_o));

    instr_encoder_loader #(.DEPTH(1), .BASE_ADDR(BASE), .COUNT_W(7)) dut1 (
        .clk(clk), .reset(reset), .clear_i(clear_i), .valid_i(valid_i), .ready_o(ready_d1),
        .op_sel_i(op_sel_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .shamt_i(shamt_i),
        .funct_i(funct_i), .imm_i(imm_i), .target_i(target_i), .mem_we_o(we_d1),
        .mem_addr_o(addr_d1), .mem_wdata_o(wdata_d1), .count_o(count_d1),
        .full_o(full_d1), .err_o(err_d1));

    // Returns {legal, word} from the instruction format rules.
    function automatic logic [32:0] model_encode(input logic [3:0] op, input logic [4:0] rs,
            input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
            input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] tgt);
        logic [5:0] opcodes [0:9];
        opcodes = '{6'h00, 6'h08, 6'h0F, 6'h0D, 6'h0C, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
        if (op > 4'd9) return {1'b0, 32'h0};
        if (op == 4'd0) return {1'b1, 6'h00, rs, rt, rd, sh, fn};
        if (op == 4'd9) return {1'b1, opcodes[9], tgt};
        if (op == 4'd2) return {1'b1, opcodes[2], 5'd0, rt, imm};
        return {1'b1, opcodes[op], rs, rt, imm};
    endfunction

    task automatic drive(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
            input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
            input logic [15:0] imm, input logic [25:0] tgt);
        op_sel_i = op; rs_i = rs; rt_i = rt; rd_i = rd; shamt_i = sh;
        funct_i = fn; imm_i = imm; target_i = tgt; valid_i = 1'b1;
    endtask

    task automatic drive_random(input logic legal_only);
        drive(legal_only ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15)),
              5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
              16'($urandom), 26'($urandom));
    endtask

    // Complete one request from an IDLE point; fields already driven with valid_i=1.
    task automatic do_req();
        logic [32:0] m;
        logic [31:0] exp_addr;
        m = model_encode(op_sel_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i, target_i);
        exp_addr = BASE + 32'(4 * exp_count);
        n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL ready_idle got %b want 1", ready_o); end
        @(posedge clk); #1; valid_i = 1'b0;
        n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL ready_encode got %b want 0", ready_o); end
        n_tests++; if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL we_encode got %b want 0", mem_we_o); end
        n_tests++; if (err_o !== !m[32]) begin n_fail++; $display("FAIL err_encode op=%0d got %b want %b", op_sel_i, err_o, !m[32]); end
        @(posedge clk); #1;
        if (m[32]) begin
            n_tests++; if (mem_we_o !== 1'b1) begin n_fail++; $display("FAIL we_write got %b want 1", mem_we_o); end
            n_tests++; if (mem_addr_o !== exp_addr) begin n_fail++; $display("FAIL addr got %h want %h", mem_addr_o, exp_addr); end
            n_tests++; if (mem_wdata_o !== m[31:0]) begin n_fail++; $display("FAIL wdata op=%0d got %h want %h", op_sel_i, mem_wdata_o, m[31:0]); end
            n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL ready_write got %b want 0", ready_o); end
            @(posedge clk); #1;
            exp_count++;
            n_tests++; if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL we_after got %b want 0", mem_we_o); end
            n_tests++; if (count_o !== 7'(exp_count)) begin n_fail++; $display("FAIL count got %0d want %0d", count_o, exp_count); end
            n_tests++; if (full_o !== (exp_count == DEPTH)) begin n_fail++; $display("FAIL full got %b want %b", full_o, exp_count == DEPTH); end
            n_tests++; if (ready_o !== (exp_count != DEPTH)) begin n_fail++; $display("FAIL ready_after got %b want %b", ready_o, exp_count != DEPTH); end
        end else begin
            n_tests++; if (mem_we_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL illegal_after we=%b err=%b want 0 0", mem_we_o, err_o); end
            n_tests++; if (count_o !== 7'(exp_count)) begin n_fail++; $display("FAIL illegal_count got %0d want %0d", count_o, exp_count); end
            n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL illegal_ready got %b want 1", ready_o); end
        end
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        @(posedge clk); #1; clear_i = 1'b0; exp_count = 0;
        n_tests++; if (count_o !== 7'd0 || full_o !== 1'b0 || ready_o !== 1'b1) begin
            n_fail++; $display("FAIL clear count=%0d full=%b ready=%b want 0 0 1", count_o, full_o, ready_o); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        n_tests++; if (ready_o !== 1'b1 || mem_we_o !== 1'b0 || full_o !== 1'b0 || err_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl ready=%b we=%b full=%b err=%b want 1 0 0 0", ready_o, mem_we_o, full_o, err_o); end
        n_tests++; if (mem_addr_o !== BASE || mem_wdata_o !== 32'h0 || count_o !== 7'd0) begin
            n_fail++; $display("FAIL reset_data addr=%h wdata=%h count=%0d want %h 0 0", mem_addr_o, mem_wdata_o, count_o, BASE); end
        exp_count = 0;
    endtask

    task automatic test_addi();
        drive(4'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0);
        do_req();
        n_tests++; if (mem_wdata_o !== 32'h2008_0005) begin n_fail++; $display("FAIL addi_word got %h want 20080005", mem_wdata_o); end
    endtask

    task automatic test_back_to_back();
        drive(4'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'd0, 26'd0);
        do_req();
        n_tests++; if (mem_wdata_o !== 32'h0109_5020) begin n_fail++; $display("FAIL rtype_word got %h want 01095020", mem_wdata_o); end
        drive(4'd9, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h010_0000);
        do_req();
        n_tests++; if (mem_wdata_o !== 32'h0810_0000) begin n_fail++; $display("FAIL j_word got %h want 08100000", mem_wdata_o); end
    endtask

    task automatic test_lui();
        do_clear();
        drive(4'd2, 5'd7, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1001, 26'd0);
        do_req();
        n_tests++; if (mem_wdata_o !== 32'h3C01_1001) begin n_fail++; $display("FAIL lui_word got %h want 3c011001", mem_wdata_o); end
    endtask

    task automatic test_illegal();
        drive(4'd12, 5'd3, 5'd4, 5'd5, 5'd6, 6'd7, 16'hBEEF, 26'd0);
        do_req();
        drive(4'd15, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1, 26'd1);
        do_req();
    endtask

    task automatic test_fill();
        do_clear();
        repeat (DEPTH) begin drive_random(1'b1); do_req(); end
        drive_random(1'b1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_tests++; if (mem_we_o !== 1'b0 || ready_o !== 1'b0 || full_o !== 1'b1) begin
                n_fail++; $display("FAIL full_hold we=%b ready=%b full=%b want 0 0 1", mem_we_o, ready_o, full_o); end
        end
        valid_i = 1'b0;
        n_tests++; if (count_o !== 7'(DEPTH)) begin n_fail++; $display("FAIL full_count got %0d want %0d", count_o, DEPTH); end
    endtask

    task automatic test_clear_write();
        do_clear();
        drive_random(1'b1); op_sel_i = 4'd1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear_i = 1'b1; #1;
        n_tests++; if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL clear_write_we got %b want 0", mem_we_o); end
        @(posedge clk); #1; clear_i = 1'b0;
        n_tests++; if (count_o !== 7'd0 || ready_o !== 1'b1) begin
            n_fail++; $display("FAIL clear_write_after count=%0d ready=%b want 0 1", count_o, ready_o); end
        clear_i = 1'b1;
        @(posedge clk); #1; clear_i = 1'b0;
        n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL clear_vs_valid ready=%b want 1", ready_o); end
        valid_i = 1'b0;
        exp_count = 0;
        drive_random(1'b1);
        do_req();
    endtask

    task automatic test_clear_full();
        do_clear();
        repeat (DEPTH) begin drive_random(1'b1); do_req(); end
        drive_random(1'b1);
        clear_i = 1'b1; #1;
        n_tests++; if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL clear_full_we got %b want 0", mem_we_o); end
        @(posedge clk); #1; clear_i = 1'b0; exp_count = 0;
        n_tests++; if (full_o !== 1'b0 || count_o !== 7'd0 || ready_o !== 1'b1) begin
            n_fail++; $display("FAIL clear_full_after full=%b count=%0d ready=%b want 0 0 1", full_o, count_o, ready_o); end
        do_req();
    endtask

    task automatic test_depth1();
        do_clear();
        n_tests++; if (full_d1 !== 1'b0 || count_d1 !== 7'd0) begin
            n_fail++; $display("FAIL d1_clear full=%b count=%0d want 0 0", full_d1, count_d1); end
        drive_random(1'b1);
        do_req();
        n_tests++; if (full_d1 !== 1'b1 || count_d1 !== 7'd1 || ready_d1 !== 1'b0) begin
            n_fail++; $display("FAIL d1_full full=%b count=%0d ready=%b want 1 1 0", full_d1, count_d1, ready_d1); end
    endtask

    task automatic test_random();
        do_clear();
        for (int i = 0; i < 40; i++) begin
            if (exp_count == DEPTH) do_clear();
            drive_random(1'b0);
            do_req();
        end
    endtask

    task automatic test_reset_mid();
        do_clear();
        drive_random(1'b1); op_sel_i = 4'd3;
        @(posedge clk); #1; valid_i = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; #1;
        n_tests++; if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_mid_we got %b want 0", mem_we_o); end
        @(posedge clk); #1; reset = 1'b0; exp_count = 0;
        n_tests++; if (count_o !== 7'd0 || ready_o !== 1'b1 || mem_wdata_o !== 32'h0 || mem_addr_o !== BASE) begin
            n_fail++; $display("FAIL reset_mid count=%0d ready=%b wdata=%h addr=%h", count_o, ready_o, mem_wdata_o, mem_addr_o); end
    endtask

    initial begin
        reset = 1'b1; clear_i = 1'b0; valid_i = 1'b0;
        drive(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0); valid_i = 1'b0;
        test_reset();
        test_addi();
        test_back_to_back();
        test_lui();
        test_illegal();
        test_fill();
        test_clear_write();
        test_clear_full();
        test_depth1();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the main control decoder: takes a decoded operation selector plus register, immediate and target fields, and assembles the 32-bit MIPS instruction word.
- Writes each assembled word sequentially into the instruction memory write port.
- Used by the boot/program-load path and by benches to build programs from field-level requests, with a valid/ready handshake, write-pointer counter and full detection.

Parameters:
- DEPTH, 64, number of instruction words the loader may write before reporting full.
- BASE_ADDR, 32'h0040_0000, byte address of the first instruction (text segment).
- COUNT_W, 7, width of the word counter; must hold DEPTH.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- clear_i  input  1  restart loading at BASE_ADDR; drop any in-flight word.
- valid_i  input  1  request carries a valid operation.
- ready_o  output  1  loader can accept a request this cycle.
- op_sel_i  input  4  0=R_TYPE, 1=ADDI, 2=LUI, 3=ORI, 4=ANDI, 5=LW, 6=SW, 7=BEQ, 8=BNE, 9=J, 10-15 illegal.
- rs_i  input  5  rs field.
- rt_i  input  5  rt field.
- rd_i  input  5  rd field (R_TYPE only).
- shamt_i  input  5  shamt field (R_TYPE only).
- funct_i  input  6  funct field (R_TYPE only).
- imm_i  input  16  immediate/offset (I-type).
- target_i  input  26  jump target (J).
- mem_we_o  output  1  instruction memory write strobe.
- mem_addr_o  output  32  byte write address.
- mem_wdata_o  output  32  assembled instruction word.
- count_o  output  COUNT_W  words written since reset/clear.
- full_o  output  1  DEPTH words written.
- err_o  output  1  one-cycle pulse: illegal op_sel dropped.

Behaviour:
- Reset values: ready_o=1, mem_we_o=0, mem_addr_o=BASE_ADDR, mem_wdata_o=0, count_o=0, full_o=0, err_o=0; state=IDLE.
- FSM states and transitions:
  - IDLE: ready_o=1. On valid_i&&ready_o, latch all fields and go to ENCODE.
  - ENCODE: ready_o=0. Register the assembled word into mem_wdata_o.
    - Legal op_sel: go to WRITE.
    - Illegal op_sel: pulse err_o and go to IDLE; no write, count unchanged.
  - WRITE: mem_we_o=1 for exactly one cycle with mem_addr_o=BASE_ADDR+4*count_o. count_o increments at the end of the cycle.
    - Go to FULL if the new count equals DEPTH, otherwise to IDLE.
  - FULL: ready_o=0, full_o=1. Hold until clear_i or reset.
- Latency: the write strobe occurs 2 cycles after the accepting edge. Throughput is one word per 3 cycles. ready_o is 1 only in IDLE.
- Encoding; all fields are truncated to their exact widths, with no sign extension:
  - R_TYPE: {6'h00, rs, rt, rd, shamt, funct}.
  - ADDI/ORI/ANDI/LW/SW/BEQ/BNE: {opcode, rs, rt, imm}, with opcodes 08, 0D, 0C, 23, 2B, 04, 05 (hex).
  - LUI: {6'h0F, 5'd0, rt, imm}; rs_i is ignored and forced to 0.
  - J: {6'h02, target}.
- mem_addr_o is a combinational function of count_o and is meaningful only when mem_we_o=1. mem_wdata_o holds its last value otherwise.
- clear_i, from any state:
  - count_o=0, full_o=0, mem_we_o=0, err_o=0; next state IDLE.
  - Overrides a simultaneous valid_i, which is not accepted.
  - Overrides a pending WRITE, which is discarded.
- reset has priority over clear_i. Reset mid-operation aborts the same way as clear_i and restores all reset values.
- valid_i while ready_o=0 is ignored. Requesters must hold fields stable until accepted.
- DEPTH=1 boundary: the first write moves the FSM directly to FULL.
- count_o never exceeds DEPTH. No write occurs while full_o=1.

Test Plan:
- Reset, then ADDI (op_sel=1, rs=0, rt=8, imm=5) -> mem_we_o pulses 2 cycles after accept; addr=0x00400000, wdata=0x20080005, count_o=1.
- R_TYPE add (rs=8, rt=9, rd=10, shamt=0, funct=0x20), then J (target=0x0100000) back-to-back -> writes 0x01095020 @0x00400000, then 0x08100000 @0x00400004; ready_o low between them.
- LUI with rs_i=7, rt=1, imm=0x1001 -> wdata=0x3C011001 (rs forced 0).
- op_sel=12 -> err_o pulses once in the ENCODE cycle; no mem_we_o; count_o unchanged; ready_o returns to 1.
- DEPTH=4: issue 5 legal requests -> 4 writes at 0x00400000..0x0040000C; full_o=1 and ready_o=0 after the 4th; the 5th is never accepted.
- Assert clear_i during WRITE, and separately while FULL -> no write that cycle; count_o=0, full_o=0; the next request writes to 0x00400000.
